// File: rtl/lsu_bus_master.sv
// Load/store unit: turns one decoded load or store into a single registered
// req/ack data-bus transaction, with lane alignment, extension and timeout.
module lsu_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRd,
    input  logic        memWr,
    input  logic [1:0]  maskSel,
    input  logic        uext,
    input  logic [31:0] addr,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    output logic        stall,
    output logic        misaligned,
    output logic        busFault,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busByteEn,
    output logic [31:0] busWrData,
    input  logic        busAck,
    input  logic [31:0] busRdData
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // Bus handshake: busReq rises from IDLE, all bus outputs stay frozen while
    // busReq=1, and the transfer completes on the first edge that sees busAck=1.
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          uext_q;

    logic          active;
    logic [1:0]    size_w;
    logic          mis_cond;
    logic [3:0]    be_w;
    logic [31:0]   wd_w;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    assign active   = memRd | memWr;
    assign size_w   = (maskSel == 2'b11) ? 2'b10 : maskSel;
    assign mis_cond = ((size_w == 2'b01) & addr[0]) |
                      ((size_w == 2'b10) & (addr[1:0] != 2'b00));

    assign misaligned = (state == IDLE) & active & mis_cond;
    assign stall      = (state == REQ) | ((state == IDLE) & active & ~mis_cond);

    always_comb begin
        be_w = 4'b1111;
        wd_w = wrData;
        case (size_w)
            2'b00: begin
                be_w = 4'b0001 << addr[1:0];
                wd_w = {4{wrData[7:0]}};
            end
            2'b01: begin
                be_w = 4'b0011 << addr[1:0];
                wd_w = {2{wrData[15:0]}};
            end
            default: begin
                be_w = 4'b1111;
                wd_w = wrData;
            end
        endcase
    end

    // Lane, size and extension mode are latched at launch so the captured
    // load does not depend on the core holding its inputs.
    always_comb begin
        shifted  = busRdData >> {lane_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = uext_q ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uext_q ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lane_q    <= 2'b00;
            size_q    <= 2'b00;
            uext_q    <= 1'b0;
            busReq    <= 1'b0;
            busWe     <= 1'b0;
            busAddr   <= 32'b0;
            busByteEn <= 4'b0;
            busWrData <= 32'b0;
            rdData    <= 32'b0;
            busFault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busFault <= 1'b0;
                    cnt      <= '0;
                    if (active && !mis_cond) begin
                        busReq    <= 1'b1;
                        busWe     <= memWr;
                        busAddr   <= {addr[31:2], 2'b00};
                        busByteEn <= be_w;
                        busWrData <= wd_w;
                        lane_q    <= addr[1:0];
                        size_q    <= size_w;
                        uext_q    <= uext;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (busAck) begin
                        busReq <= 1'b0;
                        if (!busWe) rdData <= load_ext;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        busReq   <= 1'b0;
                        rdData   <= 32'b0;
                        busFault <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    busFault <= 1'b0;
                    cnt      <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized bench for lsu_bus_master against a byte-level reference model.
module tb_lsu_bus_master;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic        memRd, memWr, uext;
    logic [1:0]  maskSel;
    logic [31:0] addr, wrData;
    logic [31:0] rdData;
    logic        stall, misaligned, busFault;
    logic        busReq, busWe;
    logic [31:0] busAddr, busWrData;
    logic [3:0]  busByteEn;
    logic        busAck;
    logic [31:0] busRdData;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    lsu_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .memRd(memRd), .memWr(memWr),
        .maskSel(maskSel), .uext(uext), .addr(addr), .wrData(wrData),
        .rdData(rdData), .stall(stall), .misaligned(misaligned),
        .busFault(busFault), .busReq(busReq), .busWe(busWe),
        .busAddr(busAddr), .busByteEn(busByteEn), .busWrData(busWrData),
        .busAck(busAck), .busRdData(busRdData)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: access size in bytes, lanes and extension by arithmetic
    function automatic int nbytes(input logic [1:0] ms);
        return (ms == 2'b00) ? 1 : (ms == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] ms, input logic [31:0] a);
        int n = nbytes(ms);
        int lane = int'(a[1:0]);
        int v;
        if (n == 4) return 4'hf;
        v = ((1 << n) - 1) << lane;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] ms, input logic [31:0] wd);
        int n = nbytes(ms);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] ms, input logic ue,
                                         input logic [31:0] a, input logic [31:0] word);
        int n = nbytes(ms);
        int lane = int'(a[1:0]);
        longint one = 1;
        longint v = 0;
        for (int j = 0; j < n; j++)
            v += longint'(word[8*(lane + j) +: 8]) << (8 * j);
        if (!ue && v >= (one << (8 * n - 1))) v -= (one << (8 * n));
        return v[31:0];
    endfunction

    // driver: one access; ack_at = REQ cycle number carrying busAck, 0 = never
    task automatic access(input logic rd, input logic wr, input logic [1:0] ms,
                          input logic ue, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int ack_at);
        int  n = nbytes(ms);
        bit  mis = (int'(a[1:0]) % n) != 0;
        bit  fault = (ack_at == 0);
        bit  fin;
        memRd = rd; memWr = wr; maskSel = ms; uext = ue; addr = a; wrData = wd;
        @(negedge clk);
        check("misaligned_c0", 32'(misaligned), 32'(mis));
        check("stall_c0", 32'(stall), 32'(!mis));
        if (mis) begin
            busAck = 1'b1;
            @(posedge clk); #1;
            busAck = 1'b0;
            @(negedge clk);
            check("mis_busreq", 32'(busReq), 32'd0);
            check("mis_stall", 32'(stall), 32'd0);
            memRd = 1'b0; memWr = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        for (int c = 1; c <= T; c++) begin
            @(negedge clk);
            check("req_busreq", 32'(busReq), 32'd1);
            check("req_stall", 32'(stall), 32'd1);
            check("req_we", 32'(busWe), 32'(wr));
            check("req_addr", busAddr, {a[31:2], 2'b00});
            check("req_be", 32'(busByteEn), 32'(m_be(ms, a)));
            check("req_wd", busWrData, m_wd(ms, wd));
            busAck    = (ack_at == c);
            busRdData = (ack_at == c) ? rw : $urandom;
            fin       = (ack_at == c) || (c == T);
            @(posedge clk); #1;
            busAck = 1'b0;
            if (fin) break;
        end
        if (fault) last_rd = 32'd0;
        else if (!wr) last_rd = m_rd(ms, ue, a, rw);
        exp_q.push_back(last_rd);
        @(negedge clk);
        check("done_busreq", 32'(busReq), 32'd0);
        check("done_stall", 32'(stall), 32'd0);
        check("done_fault", 32'(busFault), 32'(fault));
        check("done_rddata", rdData, exp_q.pop_front());
        @(posedge clk); #1;
        memRd = 1'b0; memWr = 1'b0;
        @(negedge clk);
        check("idle_fault", 32'(busFault), 32'd0);
        check("idle_busreq", 32'(busReq), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; last_rd = 32'd0;
        reset = 1'b0; memRd = 1'b0; memWr = 1'b0; maskSel = 2'b00; uext = 1'b0;
        addr = 32'd0; wrData = 32'd0; busAck = 1'b0; busRdData = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busreq", 32'(busReq), 32'd0);
        check("rst_we", 32'(busWe), 32'd0);
        check("rst_addr", busAddr, 32'd0);
        check("rst_be", 32'(busByteEn), 32'd0);
        check("rst_wd", busWrData, 32'd0);
        check("rst_rddata", rdData, 32'd0);
        check("rst_fault", 32'(busFault), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF0000, 1);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF0000, 2);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h1234ABCD, 32'h55AA55AA, 4);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h7, 32'hCAFE, 32'h0, 1);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 0);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h8001_7FFF, 3);
        access(1'b1, 1'b1, 2'b11, 1'b0, 32'h30, 32'h01020304, 32'h0, 2);

        // reset in the middle of a load's REQ phase
        memRd = 1'b1; memWr = 1'b0; maskSel = 2'b10; uext = 1'b0; addr = 32'h300;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_busreq_pre", 32'(busReq), 32'd1);
        reset = 1'b0; memRd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
        check("mid_busreq", 32'(busReq), 32'd0);
        check("mid_stall", 32'(stall), 32'd0);
        check("mid_rddata", rdData, 32'd0);
        busAck = 1'b1; busRdData = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        busAck = 1'b0;
        @(negedge clk);
        check("late_ack_busreq", 32'(busReq), 32'd0);
        check("late_ack_rddata", rdData, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 2);
            logic [31:0] a = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255));
            access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, $urandom, $urandom_range(0, T));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit: the responder for the decoder's memory-control signals (memRd/memWr, maskSel, uext).
- Turns one load or store into a single registered req/ack transaction on the data bus.
- Handles byte-lane alignment, byte enables, sign/zero extension and misalignment detection.
- Stalls the core until the access completes; sits between the execute stage and the data-memory bus.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ without busAck before the access is aborted (must be >= 2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
memRd  in  1  load request from the decoder (held stable while stall=1)
memWr  in  1  store request (held stable while stall=1)
maskSel  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
uext  in  1  1 = zero-extend loads, 0 = sign-extend
addr  in  32  byte address from the ALU
wrData  in  32  store data from rs2
rdData  out  32  extended load result, valid in DONE
stall  out  1  hold PC/pipeline
misaligned  out  1  combinational flag, address misaligned for the access size
busFault  out  1  1-cycle pulse, access aborted by timeout
busReq  out  1  registered bus request
busWe  out  1  registered write strobe
busAddr  out  32  registered word-aligned address ({addr[31:2],2'b00})
busByteEn  out  4  registered byte enables
busWrData  out  32  registered lane-replicated write data
busAck  in  1  bus completes the transfer this cycle
busRdData  in  32  read word, sampled when busAck=1

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; counter cleared.
  - busReq, busWe, busAddr, busByteEn, busWrData, rdData and busFault all become 0.
  - Applies mid-transaction too: busReq drops at that edge and the pending access is discarded.
- States: IDLE, REQ, DONE.
- IDLE:
  - A request is active when memRd|memWr.
  - memWr has priority if both are set (busWe=1).
  - misaligned=1 in IDLE when a request is active and: half with addr[0]=1; or word/11 with addr[1:0]!=0.
  - Misaligned request: stall=0, no bus transaction, state stays IDLE; the trap is taken by the core.
  - Aligned request: stall=1 combinationally in that same cycle. At the next edge, latch busAddr, busByteEn, busWrData and busWe, set busReq=1, go to REQ.
  - busAck is ignored in IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Write data:
  - byte: {4{wrData[7:0]}}
  - half: {2{wrData[15:0]}}
  - word: wrData
- REQ:
  - stall=1; busReq and all bus outputs are held stable.
  - On busAck=1: at that edge capture busRdData >> (8*addr[1:0]), truncate to the access size, extend per uext into rdData. Drop busReq, go to DONE.
  - For stores, rdData is left unchanged.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES-1: drop busReq, set rdData=0, assert busFault for the DONE cycle, go to DONE.
  - busAck in the same cycle as the timeout wins (normal completion, no fault).
- DONE:
  - stall=0 and rdData valid, so the core advances this cycle.
  - Exactly one cycle, then IDLE; counter cleared; busFault returns to 0.
  - memRd/memWr in DONE are ignored (they belong to the finishing instruction).
- Latency: request in cycle 0, busReq high from cycle 1, ack in cycle k≥1, DONE in cycle k+1. Minimum access is 3 cycles.
- No outstanding transactions beyond one; busReq never rises twice without an intervening IDLE.

Test Plan:
- Aligned word load, addr=0x100, ack in first REQ cycle, busRdData=0xDEADBEEF -> busAddr=0x100, busByteEn=1111, busWe=0; DONE in cycle 2 with rdData=0xDEADBEEF, stall high in cycles 0-1 only.
- Byte loads from addr=0x203 with busRdData=0x80FF_0000: uext=0 -> rdData=0xFFFFFF80; uext=1 -> rdData=0x00000080; busAddr=0x200, busByteEn=1000.
- Half store, addr=0x42, wrData=0x1234ABCD, ack after 3 wait cycles -> busWe=1, busByteEn=1100, busWrData=0xABCDABCD held stable for all 4 REQ cycles; busReq low in DONE.
- Misaligned word load addr=0x101 and half store addr=0x7 -> misaligned=1, stall=0, busReq stays 0 throughout.
- TIMEOUT_CYCLES=4, no ack -> busReq high exactly 4 cycles, then DONE with busFault=1 for one cycle and rdData=0; a following load completes normally.
- reset=0 during REQ of a load -> busReq=0 and state IDLE after that edge, stall deasserts, no rdData update; a late busAck is ignored.
